systolic_operand_feeder: RTL and testbench
==========================================

// Module: systolic_operand_feeder
// PURPOSE
//  Read side of the 8x8 systolic matmul: fetches A columns and B rows from two wide BRAMs,
//  skews lane i by i cycles and drives the array's west/north edges with valid.
//  After drain it holds complete_matmul high until the array's result writer reports
//  result_w_comp, then pulses done.
//  Sits between the BRAM port-A read side and the systolic array.
// PARAMETERS
//  N        8   array dimension; lanes per edge
//  DW       32  operand width per lane
//  AW       11  BRAM address width; also the width of k_len
//  PE_LAT   1   PE register latency per hop, used in drain count
// PORTS
//  clk              in   1     clock
//  rst_n            in   1     synchronous, active-low reset
//  start            in   1     begin a matmul; sampled in IDLE only
//  abort            in   1     synchronous cancel; any state -> IDLE
//  k_len            in   AW    inner dimension K; sampled with start
//  a_en / b_en      out  1     BRAM read enables
//  a_addr / b_addr  out  AW    address k = A column k / B row k
//  a_rdata/b_rdata  in   N*DW  read data, 1-cycle latency; lane i = bits [i*DW +: DW]
//  west_data        out  N*DW  lane i -> row i west input
//  north_data       out  N*DW  lane j -> column j north input
//  valid            out  1     array accumulate enable
//  rst_flush        out  1     1-cycle accumulator/writer clear
//  complete_matmul  out  1     tells result writer to dump
//  result_w_comp    in   1     writer finished dump
//  busy / done      out  1     busy = state != IDLE; done = 1-cycle pulse
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - State IDLE; all outputs 0; skew shift registers cleared to 0.
//  FSM: IDLE -> FLUSH -> LOAD -> DRAIN -> COMPLETE -> DONE -> IDLE.
//  - IDLE:
//    - start=1 and k_len!=0: latch k_len, go to FLUSH.
//    - start=1 and k_len==0: go to DONE; no flush, no reads.
//  - FLUSH (1 cycle): rst_flush=1, go to LOAD.
//  - LOAD (k_len cycles): a_en=b_en=1, addr = 0,1,..,k_len-1; go to DRAIN after the last address.
//  - Skew path:
//    - Element issued at address k appears on lane i of west_data/north_data exactly 2+i cycles later.
//    - Lane outputs are registered; every other slot on a lane is 0.
//  - valid:
//    - Rises the cycle element 0 appears on lane 0.
//    - Stays high for exactly k_len + 3*(N-1) + PE_LAT cycles.
//    - Falls at the end of DRAIN; DRAIN ends when valid's count expires.
//  - COMPLETE: complete_matmul=1, held until result_w_comp=1 is sampled; then go to DONE.
//  - DONE (1 cycle): done=1, complete_matmul=0, go to IDLE.
//  - Boundary rules:
//    - start while busy: ignored.
//    - result_w_comp outside COMPLETE: ignored.
//    - abort in any non-IDLE state: next cycle IDLE; rst_flush=1 for that one cycle;
//      skew registers zeroed; no done pulse.
//    - abort and start in the same IDLE cycle: abort wins.
//    - rst_n low mid-operation: same as reset; no rst_flush pulse.
//    - k_len = 2^AW-1: addresses must not wrap.
// CONFIGURATION
//  FEEDER_CYCLE_CNT_EN
//   - Defined: adds output cycle_cnt[31:0].
//     - Cleared on start accept; increments every cycle while busy.
//     - Holds its value after done until the next start; saturates at 0xFFFFFFFF.
//   - Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. A = B = I(8), k_len=8, result_w_comp returned 5 cycles after complete_matmul
//     -> diagonal PE results = 1, all others 0; done asserted once.
//  2. Skew check, k_len=3, a_rdata lane i = 0x100*i + k
//     -> west lane 7 shows 0x700, 0x701, 0x702 at cycles 9, 10, 11 after the first address;
//        0 otherwise.
//  3. valid width, k_len=8, N=8, PE_LAT=1 -> valid high exactly 30 consecutive cycles;
//     rst_flush pulses once, before the first a_en.
//  4. start with k_len=0 -> done 1 cycle later; no a_en, no valid, no rst_flush.
//  5. abort 4 cycles into LOAD -> next cycle IDLE with rst_flush=1 and all lanes 0;
//     a following start with k_len=8 yields correct identity results.
//  6. FEEDER_CYCLE_CNT_EN defined, k_len=8, result_w_comp 5 cycles after complete_matmul
//     -> cycle_cnt equals the busy-high cycle count; held after done.

Source files
------------

// File: rtl/systolic_operand_feeder_if.sv
// rtl/systolic_operand_feeder_if.sv - BRAM read, array edge and control bundle for the operand feeder
// Optional FEEDER_CYCLE_CNT_EN adds cycle_cnt to the bundle.
interface systolic_operand_feeder_if #(
    parameter int N  = 8,
    parameter int DW = 32,
    parameter int AW = 11
);
    logic              start;
    logic              abort;
    logic [AW-1:0]     k_len;
    logic              a_en;
    logic              b_en;
    logic [AW-1:0]     a_addr;
    logic [AW-1:0]     b_addr;
    logic [N*DW-1:0]   a_rdata;
    logic [N*DW-1:0]   b_rdata;
    logic [N*DW-1:0]   west_data;
    logic [N*DW-1:0]   north_data;
    logic              valid;
    logic              rst_flush;
    logic              complete_matmul;
    logic              result_w_comp;
    logic              busy;
    logic              done;
`ifdef FEEDER_CYCLE_CNT_EN
    logic [31:0]       cycle_cnt;
`endif

    modport master (
        output start, abort, k_len, a_rdata, b_rdata, result_w_comp,
        input  a_en, b_en, a_addr, b_addr, west_data, north_data, valid,
               rst_flush, complete_matmul, busy, done
`ifdef FEEDER_CYCLE_CNT_EN
        , input cycle_cnt
`endif
    );

    modport slave (
        input  start, abort, k_len, a_rdata, b_rdata, result_w_comp,
        output a_en, b_en, a_addr, b_addr, west_data, north_data, valid,
               rst_flush, complete_matmul, busy, done
`ifdef FEEDER_CYCLE_CNT_EN
        , output cycle_cnt
`endif
    );
endinterface

// File: rtl/systolic_operand_feeder.sv
// rtl/systolic_operand_feeder.sv - fetches A columns / B rows, skews them onto the systolic array edges
// Optional FEEDER_CYCLE_CNT_EN adds a saturating busy-cycle counter (cycle_cnt).
module systolic_operand_feeder #(
    parameter int N      = 8,
    parameter int DW     = 32,
    parameter int AW     = 11,
    parameter int PE_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    systolic_operand_feeder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_LOAD,
        S_DRAIN,
        S_COMPLETE,
        S_DONE
    } state_t;

    // r_t counts from the first address; valid spans t = 2 .. k_len + DRAIN_EXTRA.
    localparam int DRAIN_EXTRA = 3 * (N - 1) + PE_LAT + 1;
    localparam int CW          = AW + $clog2(DRAIN_EXTRA + 2);

    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_klen;
    logic [CW-1:0]    r_t;
    logic             r_rd_vld;
    logic             r_abort_flush;
    logic [DW-1:0]    r_west_sr  [N][N];
    logic [DW-1:0]    r_north_sr [N][N];

    logic             w_kill;
    logic             w_accept;
    logic             w_load;
    logic             w_run;
    logic             w_last_addr;
    logic             w_drain_end;
    logic             w_valid;
    logic [CW-1:0]    w_klen_ext;
    logic             w_a_en;
    logic             w_flush;
    logic             w_complete;
    logic             w_done;
    logic [N*DW-1:0]  w_west;
    logic [N*DW-1:0]  w_north;

    assign w_kill      = bus.abort && (r_state != S_IDLE);
    assign w_accept    = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_klen_ext  = CW'(r_klen);
    assign w_load      = (r_state == S_LOAD);
    assign w_run       = w_load || (r_state == S_DRAIN);
    assign w_last_addr = (r_t == (w_klen_ext - CW'(1)));
    assign w_drain_end = (r_t == (w_klen_ext + CW'(DRAIN_EXTRA)));
    assign w_valid     = w_run && (r_t >= CW'(2)) && (r_t <= (w_klen_ext + CW'(DRAIN_EXTRA)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_a_en     = 1'b0;
        w_flush    = r_abort_flush;
        w_complete = 1'b0;
        w_done     = 1'b0;
        if (w_kill) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_next = (bus.k_len == '0) ? S_DONE : S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    w_flush = 1'b1;
                    w_next  = S_LOAD;
                end
                S_LOAD: begin
                    w_a_en = 1'b1;
                    if (w_last_addr) begin
                        w_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_end) begin
                        w_next = S_COMPLETE;
                    end
                end
                S_COMPLETE: begin
                    w_complete = 1'b1;
                    if (bus.result_w_comp) begin
                        w_next = S_DONE;
                    end
                end
                S_DONE: begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
        // An abort still issues the LOAD read that cycle; r_rd_vld drops it.
        if (w_kill && w_load) begin
            w_a_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_klen        <= '0;
            r_t           <= '0;
            r_rd_vld      <= 1'b0;
            r_abort_flush <= 1'b0;
        end else begin
            r_abort_flush <= w_kill;
            r_rd_vld      <= w_load && !bus.abort;
            if (w_accept) begin
                r_klen <= bus.k_len;
            end
            if (r_state == S_FLUSH) begin
                r_t <= '0;
            end else if (w_run) begin
                r_t <= r_t + CW'(1);
            end
        end
    end

    // Lane i taps stage i, giving 2+i cycles from address to edge.
    always_ff @(posedge clk) begin
        if (!rst_n || w_kill) begin
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d < N; d++) begin
                    r_west_sr[i][d]  <= '0;
                    r_north_sr[i][d] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                r_west_sr[i][0]  <= r_rd_vld ? bus.a_rdata[i*DW +: DW] : '0;
                r_north_sr[i][0] <= r_rd_vld ? bus.b_rdata[i*DW +: DW] : '0;
                for (int d = 1; d < N; d++) begin
                    r_west_sr[i][d]  <= r_west_sr[i][d-1];
                    r_north_sr[i][d] <= r_north_sr[i][d-1];
                end
            end
        end
    end

    always_comb begin
        w_west  = '0;
        w_north = '0;
        for (int i = 0; i < N; i++) begin
            w_west[i*DW +: DW]  = r_west_sr[i][i];
            w_north[i*DW +: DW] = r_north_sr[i][i];
        end
    end

    assign bus.a_en            = w_a_en;
    assign bus.b_en            = w_a_en;
    assign bus.a_addr          = w_load ? r_t[AW-1:0] : '0;
    assign bus.b_addr          = w_load ? r_t[AW-1:0] : '0;
    assign bus.west_data       = w_west;
    assign bus.north_data      = w_north;
    assign bus.valid           = w_valid;
    assign bus.rst_flush       = w_flush;
    assign bus.complete_matmul = w_complete;
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.done            = w_done;

`ifdef FEEDER_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
        end else if (w_accept) begin
            r_cycle_cnt <= '0;
        end else if ((r_state != S_IDLE) && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
`endif
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// tb/tb_systolic_operand_feeder.sv - directed self-checking bench for systolic_operand_feeder
module tb_systolic_operand_feeder;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_operand_feeder_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    systolic_operand_feeder #(.N(N), .DW(DW), .AW(AW), .PE_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [N*DW-1:0] amem [16];
    logic [N*DW-1:0] bmem [16];

    always @(posedge clk) begin
        if (bus.a_en) bus.a_rdata <= amem[bus.a_addr[3:0]];
        if (bus.b_en) bus.b_rdata <= bmem[bus.b_addr[3:0]];
    end

    // Output-stationary 8x8 array fed from the edges; A flows east, B flows south.
    logic [DW-1:0] ma  [N][N];
    logic [DW-1:0] mb  [N][N];
    logic [63:0]   acc [N][N];
    logic [DW-1:0] m_ain, m_bin;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                m_ain = (j == 0) ? bus.west_data[i*DW +: DW]  : ma[i][(j == 0) ? 0 : j-1];
                m_bin = (i == 0) ? bus.north_data[j*DW +: DW] : mb[(i == 0) ? 0 : i-1][j];
                if (bus.rst_flush === 1'b1) begin
                    acc[i][j] <= '0;
                    ma[i][j]  <= '0;
                    mb[i][j]  <= '0;
                end else begin
                    if (bus.valid === 1'b1) acc[i][j] <= acc[i][j] + 64'(m_ain) * 64'(m_bin);
                    ma[i][j] <= m_ain;
                    mb[i][j] <= m_bin;
                end
            end
        end
    end

    int st_busy, st_flush, st_flush_at, st_aen, st_aen_at, st_valid, st_v_first, st_v_last;
    int st_comp, st_done, st_done_at;
    bit st_timeout;
    logic [DW-1:0] w7 [64];

    task automatic fill_identity();
        for (int k = 0; k < 16; k++) begin
            amem[k] = '0;
            bmem[k] = '0;
            if (k < N) begin
                amem[k][k*DW +: DW] = 32'd1;
                bmem[k][k*DW +: DW] = 32'd1;
            end
        end
    endtask

    task automatic fill_skew();
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < N; i++) begin
                amem[k][i*DW +: DW] = 32'h100 * i + k;
                bmem[k][i*DW +: DW] = 32'h200 * i + k;
            end
        end
    endtask

    task automatic run_op(input int k);
        int comp_at;
        bit fin;
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = AW'(k);
        @(negedge clk);
        bus.start = 1'b0;
        st_busy = 0; st_flush = 0; st_flush_at = -1; st_aen = 0; st_aen_at = -1;
        st_valid = 0; st_v_first = -1; st_v_last = -1; st_comp = 0; st_done = 0; st_done_at = -1;
        comp_at = -1;
        fin = 1'b0;
        for (int c = 0; c < 64; c++) w7[c] = '0;
        for (int c = 0; c < 300; c++) begin
            if (c < 64) w7[c] = bus.west_data[7*DW +: DW];
            if (bus.busy) st_busy++;
            if (bus.rst_flush) begin st_flush++; if (st_flush_at < 0) st_flush_at = c; end
            if (bus.a_en) begin st_aen++; if (st_aen_at < 0) st_aen_at = c; end
            if (bus.valid) begin st_valid++; if (st_v_first < 0) st_v_first = c; st_v_last = c; end
            if (bus.complete_matmul) begin st_comp++; if (comp_at < 0) comp_at = c; end
            bus.result_w_comp = (comp_at >= 0) && (c == comp_at + 5);
            if (bus.done) begin
                st_done++;
                st_done_at = c;
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.result_w_comp = 1'b0;
        st_timeout = !fin;
        @(negedge clk);
        if (bus.done) st_done++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.valid, bus.rst_flush, bus.a_en, bus.b_en, bus.complete_matmul} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.busy, bus.done, bus.valid, bus.rst_flush, bus.a_en, bus.b_en, bus.complete_matmul});
        end
        n_checks++;
        if (bus.west_data !== '0 || bus.north_data !== '0) begin
            n_fail++;
            $display("FAIL reset_lanes: west %h north %h expected 0", bus.west_data, bus.north_data);
        end
        n_checks++;
        if (bus.a_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d expected 0", bus.a_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_identity(input string tag);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (acc[i][j] !== ((i == j) ? 64'd1 : 64'd0)) begin
                    n_fail++;
                    $display("FAIL %s_c%0d%0d: got %0d expected %0d", tag, i, j, acc[i][j], (i == j) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_identity();
        fill_identity();
        run_op(8);
        n_checks++;
        if (st_timeout) begin n_fail++; $display("FAIL ident_timeout: done not seen, expected within 300 cycles"); end
        n_checks++;
        if (st_done !== 1) begin n_fail++; $display("FAIL ident_done_count: got %0d expected 1", st_done); end
        n_checks++;
        if (st_busy !== 40) begin n_fail++; $display("FAIL ident_busy_cycles: got %0d expected 40", st_busy); end
        n_checks++;
        if (st_comp !== 6) begin n_fail++; $display("FAIL ident_complete_cycles: got %0d expected 6", st_comp); end
        n_checks++;
        if (st_aen !== 8) begin n_fail++; $display("FAIL ident_aen_cycles: got %0d expected 8", st_aen); end
        check_identity("ident");
    endtask

    task automatic test_skew();
        logic [DW-1:0] exp_v;
        fill_skew();
        run_op(3);
        n_checks++;
        if (st_aen_at !== 1) begin n_fail++; $display("FAIL skew_first_addr: got %0d expected 1", st_aen_at); end
        for (int rel = 0; rel < 16; rel++) begin
            exp_v = (rel >= 9 && rel <= 11) ? (32'h700 + 32'(rel - 9)) : 32'h0;
            n_checks++;
            if (w7[1 + rel] !== exp_v) begin
                n_fail++;
                $display("FAIL skew_lane7_t%0d: got %h expected %h", rel, w7[1 + rel], exp_v);
            end
        end
    endtask

    task automatic test_valid_width();
        fill_skew();
        run_op(8);
        n_checks++;
        if (st_valid !== 30) begin n_fail++; $display("FAIL valid_count: got %0d expected 30", st_valid); end
        n_checks++;
        if (st_v_first !== 3 || st_v_last !== 32) begin
            n_fail++;
            $display("FAIL valid_window: got %0d..%0d expected 3..32", st_v_first, st_v_last);
        end
        n_checks++;
        if (st_flush !== 1 || st_flush_at !== 0) begin
            n_fail++;
            $display("FAIL flush_pulse: got count %0d at %0d expected count 1 at 0", st_flush, st_flush_at);
        end
        n_checks++;
        if (st_done_at !== 39) begin n_fail++; $display("FAIL valid_done_at: got %0d expected 39", st_done_at); end
    endtask

    task automatic test_k_zero();
        run_op(0);
        n_checks++;
        if (st_done_at !== 0 || st_done !== 1) begin
            n_fail++;
            $display("FAIL kzero_done: got at %0d count %0d expected at 0 count 1", st_done_at, st_done);
        end
        n_checks++;
        if (st_aen !== 0 || st_valid !== 0 || st_flush !== 0) begin
            n_fail++;
            $display("FAIL kzero_activity: aen %0d valid %0d flush %0d expected 0 0 0", st_aen, st_valid, st_flush);
        end
        n_checks++;
        if (st_busy !== 1) begin n_fail++; $display("FAIL kzero_busy: got %0d expected 1", st_busy); end
    endtask

    task automatic test_abort();
        bit seen;
        fill_identity();
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = AW'(8);
        @(negedge clk);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.a_en) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL abort_load_seen: got no a_en expected a_en within 20 cycles"); end
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.west_data === '0) begin n_fail++; $display("FAIL abort_lanes_live: got 0 expected nonzero west lanes"); end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.rst_flush !== 1'b1 || bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next: busy %b flush %b valid %b expected 0 1 0", bus.busy, bus.rst_flush, bus.valid);
        end
        n_checks++;
        if (bus.west_data !== '0 || bus.north_data !== '0) begin
            n_fail++;
            $display("FAIL abort_lanes: west %h north %h expected 0", bus.west_data, bus.north_data);
        end
        @(negedge clk);
        n_checks++;
        if (bus.rst_flush !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.west_data !== '0) begin
            n_fail++;
            $display("FAIL abort_after: flush %b done %b busy %b expected 0 0 0 lanes 0", bus.rst_flush, bus.done, bus.busy);
        end
        run_op(8);
        n_checks++;
        if (st_timeout || st_done !== 1) begin
            n_fail++;
            $display("FAIL abort_rerun_done: timeout %b count %0d expected 0 1", st_timeout, st_done);
        end
        check_identity("abort_rerun");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = AW'(8);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.rst_flush !== 1'b0 || bus.valid !== 1'b0 || bus.a_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: busy %b flush %b valid %b aen %b expected 0 0 0 0",
                     bus.busy, bus.rst_flush, bus.valid, bus.a_en);
        end
        n_checks++;
        if (bus.west_data !== '0 || bus.north_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_lanes: west %h north %h expected 0", bus.west_data, bus.north_data);
        end
        @(negedge clk);
    endtask

`ifdef FEEDER_CYCLE_CNT_EN
    task automatic test_cycle_cnt();
        fill_identity();
        run_op(8);
        n_checks++;
        if (bus.cycle_cnt !== 32'd40) begin n_fail++; $display("FAIL cycle_cnt_final: got %0d expected 40", bus.cycle_cnt); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.cycle_cnt !== 32'd40) begin n_fail++; $display("FAIL cycle_cnt_hold: got %0d expected 40", bus.cycle_cnt); end
    endtask
`endif

    initial begin
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.k_len         = '0;
        bus.result_w_comp = 1'b0;
        test_reset();
        test_identity();
        test_skew();
        test_valid_width();
        test_k_zero();
        test_abort();
        test_reset_mid();
`ifdef FEEDER_CYCLE_CNT_EN
        test_cycle_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
